// File: rtl/decode_issue.sv
// Decode and issue stage: decodes one 16-bit instruction per transfer into a
// single EX register. Writeback, operand forwarding and branch redirect are
// all resolved while an instruction sits in EX.
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  fetch_pc,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    output logic        redirect,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;

    state_t      r_state;
    state_t      w_nextState;

    // Entry 0 is cleared at reset and never written, so r0 always reads 0.
    logic [7:0]  r_regFile [8];

    logic        r_exValid;
    logic [3:0]  r_aluOp;
    logic [7:0]  r_aluA;
    logic [7:0]  r_aluB;
    logic [2:0]  r_exRd;
    logic [7:0]  r_exPc;
    logic [7:0]  r_exOff;
    logic [7:0]  r_fetchPc;

    logic [3:0]  w_op;
    logic [2:0]  w_f1;
    logic [2:0]  w_f2;
    logic [2:0]  w_f3;
    logic [7:0]  w_imm;
    logic        w_isRType;
    logic        w_isAddi;
    logic        w_isBranch;
    logic [2:0]  w_srcA;
    logic [2:0]  w_srcB;
    logic [7:0]  w_srcAVal;
    logic [7:0]  w_srcBVal;
    logic        w_transfer;
    logic        w_exWrites;
    logic        w_wbEn;
    logic        w_taken;

    logic        w_dValid;
    logic [3:0]  w_dOp;
    logic [7:0]  w_dA;
    logic [7:0]  w_dB;
    logic [2:0]  w_dRd;
    logic [7:0]  w_dOff;

    assign w_op       = instr[15:12];
    assign w_f1       = instr[11:9];
    assign w_f2       = instr[8:6];
    assign w_f3       = instr[5:3];
    assign w_imm      = {{2{instr[5]}}, instr[5:0]};
    assign w_isRType  = (w_op <= 4'd5);
    assign w_isAddi   = (w_op == OP_ADDI);
    assign w_isBranch = (w_op == OP_BEQ) || (w_op == OP_BNE);

    // Branches compare f1/f2, everything else reads f2/f3.
    assign w_srcA = w_isBranch ? w_f1 : w_f2;
    assign w_srcB = w_isBranch ? w_f2 : w_f3;

    assign w_transfer = instr_valid && instr_ready;
    assign w_exWrites = r_exValid && ((r_aluOp <= 4'd5) || (r_aluOp == OP_ADDI));
    assign w_wbEn     = w_exWrites && (r_exRd != 3'd0);
    assign w_taken    = r_exValid && (((r_aluOp == OP_BEQ) && alu_zero) ||
                                      ((r_aluOp == OP_BNE) && !alu_zero));

    assign instr_ready = (r_state == RUN);
    assign redirect    = w_taken;
    assign fetch_pc    = r_fetchPc;
    assign alu_a       = r_aluA;
    assign alu_b       = r_aluB;
    assign alu_op      = r_aluOp;
    assign dbg_data    = r_regFile[dbg_addr];

    // Operand read with bypass of the result EX is writing back this cycle.
    always_comb begin
        w_srcAVal = r_regFile[w_srcA];
        w_srcBVal = r_regFile[w_srcB];
        if (w_wbEn && (r_exRd == w_srcA)) w_srcAVal = alu_result;
        if (w_wbEn && (r_exRd == w_srcB)) w_srcBVal = alu_result;
    end

    // Decode the incoming instruction into the next EX contents; a missing
    // transfer, an unknown op or a taken branch all produce a bubble.
    always_comb begin
        w_dValid = 1'b0;
        w_dOp    = 4'd0;
        w_dA     = 8'd0;
        w_dB     = 8'd0;
        w_dRd    = 3'd0;
        w_dOff   = 8'd0;
        if (w_transfer && !w_taken) begin
            if (w_isRType) begin
                w_dValid = 1'b1;
                w_dOp    = w_op;
                w_dA     = w_srcAVal;
                w_dB     = w_srcBVal;
                w_dRd    = w_f1;
            end else if (w_isAddi) begin
                w_dValid = 1'b1;
                w_dOp    = w_op;
                w_dA     = w_srcAVal;
                w_dB     = w_imm;
                w_dRd    = w_f1;
            end else if (w_isBranch) begin
                w_dValid = 1'b1;
                w_dOp    = w_op;
                w_dA     = w_srcAVal;
                w_dB     = w_srcBVal;
                w_dOff   = w_imm;
            end
        end
    end

    // Next-state logic: a taken branch costs one cycle of stalled fetch.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_taken) w_nextState = FLUSH;
            FLUSH:   w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_nextState;
    end

    // EX pipeline register, reloaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exValid <= 1'b0;
            r_aluOp   <= 4'd0;
            r_aluA    <= 8'd0;
            r_aluB    <= 8'd0;
            r_exRd    <= 3'd0;
            r_exPc    <= 8'd0;
            r_exOff   <= 8'd0;
        end else begin
            r_exValid <= w_dValid;
            r_aluOp   <= w_dOp;
            r_aluA    <= w_dA;
            r_aluB    <= w_dB;
            r_exRd    <= w_dRd;
            r_exPc    <= r_fetchPc;
            r_exOff   <= w_dOff;
        end
    end

    // Fetch address: branch target wins over sequential increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_fetchPc <= 8'd0;
        else if (w_taken)    r_fetchPc <= r_exPc + 8'd1 + r_exOff;
        else if (w_transfer) r_fetchPc <= r_fetchPc + 8'd1;
    end

    // Register file writeback at the end of the EX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_regFile[i] <= 8'd0;
        end else if (w_wbEn) begin
            r_regFile[r_exRd] <= alu_result;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: the bench plays the ALU and keeps an
// architectural model (register values, pc, the instruction held in EX).
module tb_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  fetch_pc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        redirect;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int compareCount;
    int mismatchCount;

    // Model state
    logic [7:0]  mRegs [8];
    logic [7:0]  mPc;
    logic        mFlush;
    logic        mExValid;
    logic [3:0]  mExOp;
    logic [7:0]  mExA;
    logic [7:0]  mExB;
    logic [2:0]  mExRd;
    logic [7:0]  mExPc;
    logic [7:0]  mExOff;

    decode_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .fetch_pc    (fetch_pc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .redirect    (redirect),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] aluFn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            4'd0, 4'd9:   return a + b;
            4'd1:         return a - b;
            4'd2:         return a & b;
            4'd3:         return a | b;
            4'd4:         return a ^ b;
            4'd5:         return (a < b) ? 8'd1 : 8'd0;
            4'd11, 4'd12: return a - b;
            default:      return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] sext6(input logic [5:0] v);
        return {{2{v[5]}}, v};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mRegs[i] = 8'd0;
        mPc = 8'd0;  mFlush = 1'b0;
        mExValid = 1'b0; mExOp = 4'd0; mExA = 8'd0; mExB = 8'd0;
        mExRd = 3'd0; mExPc = 8'd0; mExOff = 8'd0;
    endtask

    task automatic applyReset();
        instr_valid = 1'b0;
        instr       = 16'd0;
        rst_n       = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstReady", instr_ready, 1'b1);
        checkOutput("rstPc",    fetch_pc,    8'd0);
        checkOutput("rstAluA",  alu_a,       8'd0);
        checkOutput("rstAluB",  alu_b,       8'd0);
        checkOutput("rstAluOp", alu_op,      4'd0);
        checkOutput("rstRedir", redirect,    1'b0);
        rst_n = 1'b1;
        modelReset();
    endtask

    // One clock cycle: ALU response + output checks against the model, then
    // drive the next instruction and advance the model past the coming edge.
    task automatic applyStimulus(input logic v, input logic [15:0] ins);
        logic [7:0] res;
        logic [7:0] view [8];
        logic       writes, taken, xfer;
        logic [3:0] op;
        logic [2:0] f1, f2, f3, da;
        @(negedge clk);
        res        = aluFn(mExOp, mExA, mExB);
        alu_result = res;
        alu_zero   = (res == 8'd0);
        da         = 3'($urandom_range(0, 7));
        dbg_addr   = da;
        #1;
        writes = mExValid && ((mExOp <= 4'd5) || (mExOp == 4'd9));
        taken  = mExValid && (((mExOp == 4'd11) && (res == 8'd0)) ||
                              ((mExOp == 4'd12) && (res != 8'd0)));
        checkOutput("aluOp",  alu_op,      mExOp);
        checkOutput("aluA",   alu_a,       mExA);
        checkOutput("aluB",   alu_b,       mExB);
        checkOutput("ready",  instr_ready, !mFlush);
        checkOutput("pc",     fetch_pc,    mPc);
        checkOutput("redir",  redirect,    taken);
        checkOutput("dbg",    dbg_data,    mRegs[da]);

        instr_valid = v;
        instr       = ins;
        xfer        = v && !mFlush;

        // Register values as the decoder should see them (pending write applied).
        for (int i = 0; i < 8; i++) view[i] = mRegs[i];
        if (writes && mExRd != 3'd0) view[mExRd] = res;

        op = ins[15:12]; f1 = ins[11:9]; f2 = ins[8:6]; f3 = ins[5:3];
        for (int i = 0; i < 8; i++) mRegs[i] = view[i];
        if (taken)     mPc = mExPc + 8'd1 + mExOff;
        else if (xfer) mPc = mPc + 8'd1;
        mExPc    = mPc;
        mExPc    = (taken || !xfer) ? mExPc : mPc - 8'd1;
        mExValid = 1'b0; mExOp = 4'd0; mExA = 8'd0; mExB = 8'd0;
        mExRd = 3'd0; mExOff = 8'd0;
        if (xfer && !taken) begin
            if (op <= 4'd5) begin
                mExValid = 1'b1; mExOp = op; mExA = view[f2]; mExB = view[f3]; mExRd = f1;
            end else if (op == 4'd9) begin
                mExValid = 1'b1; mExOp = op; mExA = view[f2]; mExB = sext6(ins[5:0]); mExRd = f1;
            end else if (op == 4'd11 || op == 4'd12) begin
                mExValid = 1'b1; mExOp = op; mExA = view[f1]; mExB = view[f2];
                mExOff = sext6(ins[5:0]);
            end
        end
        mFlush = taken;
    endtask

    task automatic checkReg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        checkOutput(tag, dbg_data, exp);
    endtask

    function automatic logic [15:0] randomInstr();
        logic [3:0] op;
        logic [3:0] others [7];
        int kind;
        others = '{4'd6, 4'd7, 4'd8, 4'd10, 4'd13, 4'd14, 4'd15};
        kind = $urandom_range(0, 9);
        if (kind <= 4)      op = 4'($urandom_range(0, 5));
        else if (kind <= 6) op = 4'd9;
        else if (kind == 7) op = 4'd11;
        else if (kind == 8) op = 4'd12;
        else                op = others[$urandom_range(0, 6)];
        return {op, 12'($urandom())};
    endfunction

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        alu_result    = 8'd0;
        alu_zero      = 1'b1;
        dbg_addr      = 3'd0;
        modelReset();
        applyReset();

        // ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2 back to back
        applyStimulus(1'b1, 16'h9205);
        applyStimulus(1'b1, 16'h9403);
        applyStimulus(1'b1, {4'h0, 3'd3, 3'd1, 3'd2, 3'd0});
        applyStimulus(1'b0, 16'h0000);
        checkOutput("addFwdA", alu_a, 8'd5);
        checkOutput("addFwdB", alu_b, 8'd3);
        applyStimulus(1'b0, 16'h0000);
        checkReg("addR3", 3'd3, 8'd8);

        // ADDI r1,r0,-1
        applyReset();
        applyStimulus(1'b1, 16'h923F);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("addiNegB", alu_b, 8'hFF);
        applyStimulus(1'b0, 16'h0000);
        checkReg("addiNegR1", 3'd1, 8'hFF);

        // BEQ r0,r0,+4 from pc 10; the next transfer is discarded
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'hF000);
        applyStimulus(1'b1, 16'hB004);
        applyStimulus(1'b1, 16'h9A09);
        checkOutput("beqRedir", redirect, 1'b1);
        applyStimulus(1'b1, 16'h9A09);
        checkOutput("beqReady0", instr_ready, 1'b0);
        checkOutput("beqPc", fetch_pc, 8'd15);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("beqReady1", instr_ready, 1'b1);
        checkReg("beqNoWrite", 3'd5, 8'd0);

        // BNE with equal operands: not taken
        applyReset();
        applyStimulus(1'b1, {4'hC, 3'd1, 3'd1, 6'd2});
        applyStimulus(1'b0, 16'h0000);
        checkOutput("bneRedir", redirect, 1'b0);
        checkOutput("bnePc", fetch_pc, 8'd1);

        // 256 unknown-op transfers wrap the pc
        applyReset();
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, {4'hF, 12'($urandom())});
        applyStimulus(1'b0, 16'h0000);
        checkOutput("wrapPc", fetch_pc, 8'd0);
        for (int i = 0; i < 8; i++) checkReg("wrapRegs", 3'(i), 8'd0);

        // Reset pulse while ADDI r4,r0,7 is in EX
        applyStimulus(1'b1, 16'h9807);
        @(negedge clk);
        instr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstA",  alu_a,  8'd0);
        checkOutput("midRstB",  alu_b,  8'd0);
        checkOutput("midRstOp", alu_op, 4'd0);
        #1 rst_n = 1'b1;
        modelReset();
        applyStimulus(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000);
        checkReg("midRstR4", 3'd4, 8'd0);

        // Randomized traffic against the model
        applyReset();
        for (int i = 0; i < 3000; i++)
            applyStimulus(($urandom_range(0, 9) < 8), randomInstr());
        applyStimulus(1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: instr_valid  input  1  fetch presents an instruction this cycle.
REQ-004: instr  input  16  instruction word: [15:12] op, [11:9] f1, [8:6] f2, [5:3] f3, [5:0] imm6.
REQ-005: instr_ready  output  1  decoder accepts instr this cycle; a transfer occurs when instr_valid and instr_ready are both high.
REQ-006: fetch_pc  output  8  address of the next instruction to fetch.
REQ-007: alu_a, alu_b  output  8 each  registered operands driven to the ALU.
REQ-008: alu_op  output  4  registered opcode driven to the ALU.
REQ-009: alu_result  input  8  combinational ALU result for the current EX contents.
REQ-010: alu_zero  input  1  ALU zero flag for the current EX contents.
REQ-011: redirect  output  1  one-cycle pulse: branch taken in EX.
REQ-012: dbg_addr  input  3, dbg_data  output  8  combinational register-file read port for test.

Function
REQ-013: Register file SHALL be 8 x 8-bit; r0 SHALL read 0 and ignore writes.
REQ-014: Decode formats SHALL be: R-type (op 0000-0101) rd=f1, rs=f2, rt=f3; ADDI (1001) rd=f1, rs=f2, b=sign-extended imm6; BEQ (1011)/BNE (1100) rs=f1, rt=f2, off=sign-extended imm6.
REQ-015: Any other op SHALL issue as a bubble: alu_op, alu_a and alu_b all 0, no writeback, no branch.
REQ-016: On a transfer, the EX register SHALL load op, operands, rd, pc and a valid bit at the next edge; latency from transfer to ALU inputs SHALL be exactly 1 cycle.
REQ-017: Cycles without a transfer SHALL load a bubble into EX (valid=0, alu_op=0, alu_a=0, alu_b=0).
REQ-018: Writeback: when EX is valid and op is R-type or ADDI, alu_result SHALL be written to rd at the end of the EX cycle.
REQ-019: Forwarding: when a decode source register equals the EX rd being written that cycle (rd not r0), the operand SHALL take alu_result instead of the register file.
REQ-020: Branch resolution in EX: BEQ taken iff alu_zero=1; BNE taken iff alu_zero=0.
REQ-021: On a taken branch: redirect=1 that cycle; fetch_pc SHALL load EX.pc+1+off (8-bit modulo arithmetic) at the next edge; any instruction transferred that same cycle SHALL be discarded (EX gets a bubble, fetch_pc does not increment).
REQ-022: Otherwise fetch_pc SHALL increment by 1 (wrapping 8'hFF->8'h00) on each transfer and hold when there is none.
REQ-023: FSM states: RUN, FLUSH. RUN->FLUSH on a taken branch; FLUSH->RUN unconditionally after 1 cycle.
REQ-024: instr_ready SHALL be 1 in RUN and 0 in FLUSH.
REQ-025: Branches and bubbles SHALL NOT write the register file.

Reset
REQ-026: While rst_n=0 (asynchronous assertion): state=RUN; fetch_pc=0; EX=bubble; alu_a=alu_b=alu_op=0; redirect=0; all registers=0.
REQ-027: Reset asserted mid-operation SHALL discard any in-flight EX instruction and its pending writeback.
REQ-028: instr_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-029: Reset, then ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2 on consecutive cycles -> alu_a=5 and alu_b=3 for ADD with r2 forwarded; dbg r3=8.
REQ-030: ADDI r1,r0,-1 (imm6=6'h3F) -> alu_b=8'hFF; r1=8'hFF.
REQ-031: BEQ r0,r0,off=+4 issued from pc 10 -> redirect pulse; fetch_pc=15; the instruction transferred in the redirect cycle is discarded (no write); instr_ready=0 for one cycle.
REQ-032: BNE with equal operands -> no redirect; fetch_pc increments normally.
REQ-033: 256 back-to-back transfers of op 1111 -> fetch_pc wraps to 0; alu_op/alu_a/alu_b stay 0; no register changes.
REQ-034: ADDI r4,r0,7 in EX with rst_n pulsed low mid-cycle -> outputs 0 immediately; r4 reads 0 after release.
